// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port KFSDRAM request arbiter.
// Port indices double as grant values and as the data-out/ack vector index.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam logic       PORT_CPU       = 1'b0;
    localparam logic       PORT_AUX       = 1'b1;
    localparam logic [9:0] ACCESS_NUM_ONE = 10'h001;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int NUM_PORTS = 2;

    // Saturating increment used by the starvation counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
        return (value >= limit) ? limit : value + 4'd1;
    endfunction

endpackage

// File: rtl/sdram_arb_priority.sv
// Port selection with bounded starvation: port 0 wins ties until port 1 has
// been passed over STARVE_LIMIT consecutive times.
module sdram_arb_priority
    import sdram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic grant_strobe,
    output logic grant_idx
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        grant_idx = PORT_CPU;
        if (req1 && (!req0 || starve_cnt_q == LIMIT)) begin
            grant_idx = PORT_AUX;
        end
    end

    // Only port-0 grants taken over a waiting port 1 count towards starvation.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_strobe) begin
            if (grant_idx == PORT_AUX || !req1) begin
                starve_cnt_d = 4'd0;
            end else begin
                starve_cnt_d = sat_inc(starve_cnt_q, LIMIT);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single KFSDRAM request interface between the CPU path (port 0)
// and an auxiliary master (port 1); one latched transaction at a time.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              p0_read,
    input  logic              p0_write,
    input  logic [ADDR_W-1:0] p0_address,
    input  logic [DATA_W-1:0] p0_data_in,
    output logic [DATA_W-1:0] p0_data_out,
    output logic              p0_ack,

    input  logic              p1_read,
    input  logic              p1_write,
    input  logic [ADDR_W-1:0] p1_address,
    input  logic [DATA_W-1:0] p1_data_in,
    output logic [DATA_W-1:0] p1_data_out,
    output logic              p1_ack,

    output logic [ADDR_W-1:0] access_address,
    output logic [9:0]        access_num,
    output logic [DATA_W-1:0] access_data_in,
    output logic              write_request,
    output logic              read_request,
    input  logic [DATA_W-1:0] access_data_out,
    input  logic              write_flag,
    input  logic              read_flag,
    input  logic              idle,
    input  logic              refresh_mode,

    output logic              initialized,
    output logic              grant
);

    arb_state_t               state_q;
    logic                     grant_q;
    logic                     op_write_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     write_req_q;
    logic                     read_req_q;
    logic [NUM_PORTS-1:0]     ack_q;
    logic                     initialized_q;

    logic [NUM_PORTS-1:0]     port_read;
    logic [NUM_PORTS-1:0]     port_write;
    logic [NUM_PORTS-1:0]     port_req;
    logic [ADDR_W-1:0]        port_addr  [NUM_PORTS];
    logic [DATA_W-1:0]        port_wdata [NUM_PORTS];

    logic                     grant_idx;
    logic                     grant_strobe;
    logic                     sel_write;
    logic                     flag_match;
    logic                     capture_en;

    assign port_read     = {p1_read,  p0_read};
    assign port_write    = {p1_write, p0_write};
    assign port_addr[0]  = p0_address;
    assign port_addr[1]  = p1_address;
    assign port_wdata[0] = p0_data_in;
    assign port_wdata[1] = p1_data_in;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_req
            assign port_req[gi] = port_read[gi] | port_write[gi];
        end
    endgenerate

    // Refresh and init both hold idle low, so no grant can slip in under them.
    assign grant_strobe = (state_q == IDLE) && idle && (|port_req);

    // Read and write together on one port is treated as a write.
    assign sel_write  = port_write[grant_idx];
    assign flag_match = op_write_q ? write_flag : read_flag;
    assign capture_en = (state_q == XFER) && !op_write_q && read_flag;

    sdram_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clock        (clock),
        .reset        (reset),
        .req0         (port_req[0]),
        .req1         (port_req[1]),
        .grant_strobe (grant_strobe),
        .grant_idx    (grant_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= PORT_CPU;
            op_write_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            write_req_q   <= 1'b0;
            read_req_q    <= 1'b0;
            ack_q         <= '0;
            initialized_q <= 1'b0;
        end else begin
            ack_q <= '0;
            if (idle) begin
                initialized_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (grant_strobe) begin
                        grant_q     <= grant_idx;
                        op_write_q  <= sel_write;
                        addr_q      <= port_addr[grant_idx];
                        wdata_q     <= port_wdata[grant_idx];
                        write_req_q <= sel_write;
                        read_req_q  <= !sel_write;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (flag_match) begin
                        write_req_q <= 1'b0;
                        read_req_q  <= 1'b0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    if (!flag_match) begin
                        ack_q[grant_q] <= 1'b1;
                        addr_q         <= '0;
                        wdata_q        <= '0;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Each port keeps its last read word until its next read completes.
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [DATA_W-1:0] data_out_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    data_out_q <= '0;
                end else if (capture_en && grant_q == 1'(gi)) begin
                    data_out_q <= access_data_out;
                end
            end
        end
    endgenerate

    assign p0_data_out    = g_port[0].data_out_q;
    assign p1_data_out    = g_port[1].data_out_q;
    assign p0_ack         = ack_q[0];
    assign p1_ack         = ack_q[1];
    assign access_address = addr_q;
    assign access_data_in = wdata_q;
    assign access_num     = ACCESS_NUM_ONE;
    assign write_request  = write_req_q;
    assign read_request   = read_req_q;
    assign initialized    = initialized_q;
    assign grant          = grant_q;

endmodule
